// File: rtl/dma_read_block.sv
// DMA read engine: queues read commands, splits them into Avalon-MM bursts,
// forwards returned beats to the data FIFO and posts one status word per command.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued command
// LD_CMD    | pop the queue, latch address/bytes/remaining beats
// CHECK     | wait for room in the data FIFO, size the next burst
// RD_REQ    | hold the read request until waitrequest drops
// WAIT_DATA | collect the beats of the outstanding burst
// STATUS    | wait for room in the status FIFO, post the status word
module dma_read_block #(
    parameter int CMD_FIFO_DEPTH = 32,
    parameter int MAX_BURST      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dma_rd_fifo_command_req_i,
    input  logic [15:0]  dma_rd_bytes_to_transfer_i,
    input  logic [31:0]  dma_rd_addr_i,
    output logic         dma_rd_fifo_full_o,
    output logic [31:0]  rd_master_addr_o,
    output logic         rd_master_read_o,
    output logic [10:0]  rd_master_bcount_o,
    input  logic         rd_master_wait_req_i,
    input  logic [255:0] rd_master_data_i,
    input  logic         rd_master_data_valid_i,
    output logic [255:0] dma_data_o,
    output logic         dma_data_fifo_wr_req_o,
    input  logic         dma_data_fifo_almost_full_i,
    output logic         dma_status_fifo_wr_req_o,
    output logic [24:0]  dma_status_fifo_data_o,
    input  logic         dma_status_fifo_almost_full_i
);

    localparam int PW = $clog2(CMD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [11:0] MAX_BURST_W = 12'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE, LD_CMD, CHECK, RD_REQ, WAIT_DATA, STATUS
    } state_t;

    state_t state, state_nxt;

    logic [47:0]   cmd_mem [CMD_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [47:0]   head;
    logic [15:0]   head_bytes;
    logic [11:0]   head_beats;

    logic [31:0]   cur_addr;
    logic [15:0]   cmd_bytes;
    logic [11:0]   remaining;
    logic [10:0]   beats_left;
    logic [10:0]   burst;
    logic [7:0]    seq;
    logic          last_beat;

    assign dma_rd_fifo_full_o = (count == CW'(CMD_FIFO_DEPTH));
    // a push while full is dropped regardless of a simultaneous pop
    assign push       = dma_rd_fifo_command_req_i && !dma_rd_fifo_full_o;
    assign pop        = (state == LD_CMD);
    assign head       = cmd_mem[rd_ptr];
    assign head_bytes = head[47:32];
    assign head_beats = {1'b0, head_bytes[15:5]} + {11'b0, |head_bytes[4:0]};

    assign burst      = (remaining > MAX_BURST_W) ? MAX_BURST_W[10:0] : remaining[10:0];
    assign last_beat  = rd_master_data_valid_i && (beats_left == 11'd1);
    assign rd_master_read_o = (state == RD_REQ);

    always_ff @(posedge clk) begin
        if (push) cmd_mem[wr_ptr] <= {dma_rd_bytes_to_transfer_i, dma_rd_addr_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (count != '0) state_nxt = LD_CMD;
            LD_CMD:    state_nxt = (head_beats == 12'd0) ? STATUS : CHECK;
            CHECK:     if (!dma_data_fifo_almost_full_i) state_nxt = RD_REQ;
            RD_REQ:    if (!rd_master_wait_req_i) state_nxt = WAIT_DATA;
            WAIT_DATA: if (last_beat) state_nxt = (remaining != 12'd1) ? CHECK : STATUS;
            STATUS:    if (!dma_status_fifo_almost_full_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr                 <= '0;
            cmd_bytes                <= '0;
            remaining                <= '0;
            beats_left               <= '0;
            seq                      <= '0;
            rd_master_addr_o         <= '0;
            rd_master_bcount_o       <= '0;
            dma_data_o               <= '0;
            dma_data_fifo_wr_req_o   <= 1'b0;
            dma_status_fifo_wr_req_o <= 1'b0;
            dma_status_fifo_data_o   <= '0;
        end else begin
            dma_data_fifo_wr_req_o   <= 1'b0;
            dma_status_fifo_wr_req_o <= 1'b0;
            case (state)
                LD_CMD: begin
                    cur_addr  <= head[31:0];
                    cmd_bytes <= head_bytes;
                    remaining <= head_beats;
                end
                CHECK: if (!dma_data_fifo_almost_full_i) begin
                    rd_master_addr_o   <= cur_addr;
                    rd_master_bcount_o <= burst;
                end
                RD_REQ: if (!rd_master_wait_req_i) beats_left <= rd_master_bcount_o;
                WAIT_DATA: if (rd_master_data_valid_i) begin
                    dma_data_o             <= rd_master_data_i;
                    dma_data_fifo_wr_req_o <= 1'b1;
                    beats_left             <= beats_left - 11'd1;
                    remaining              <= remaining - 12'd1;
                    // next burst starts right after the one just completed
                    if (last_beat) cur_addr <= cur_addr + {16'b0, rd_master_bcount_o, 5'b0};
                end
                STATUS: if (!dma_status_fifo_almost_full_i) begin
                    dma_status_fifo_wr_req_o <= 1'b1;
                    dma_status_fifo_data_o   <= {(cmd_bytes == 16'd0), seq, cmd_bytes};
                    seq                      <= seq + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dma_read_block.md
Name: dma_read_block

Overview:
- Read-side counterpart of the DMA write engine.
- Accepts read commands (source address, byte count) from the descriptor processor and queues them internally.
- Splits each command into Avalon-MM burst reads of at most MAX_BURST 256-bit beats and pushes returned data into the DMA data FIFO.
- Posts one status word per completed command to the status update block.

Parameters:
CMD_FIFO_DEPTH, 32, command queue depth in entries (power of 2, >=2)
MAX_BURST, 16, max beats per AVMM burst (1..1024)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
dma_rd_fifo_command_req_i  in  1  push command (one cycle per command)
dma_rd_bytes_to_transfer_i  in  16  command byte count
dma_rd_addr_i  in  32  command source byte address (32B-aligned)
dma_rd_fifo_full_o  out  1  command queue full
rd_master_addr_o  out  32  AVMM burst start address
rd_master_read_o  out  1  AVMM read request
rd_master_bcount_o  out  11  AVMM burst count, in beats
rd_master_wait_req_i  in  1  AVMM waitrequest
rd_master_data_i  in  256  AVMM readdata
rd_master_data_valid_i  in  1  AVMM readdatavalid
dma_data_o  out  256  data to DMA data FIFO
dma_data_fifo_wr_req_o  out  1  DMA data FIFO write strobe
dma_data_fifo_almost_full_i  in  1  DMA data FIFO almost full
dma_status_fifo_wr_req_o  out  1  status FIFO write strobe
dma_status_fifo_data_o  out  25  status word
dma_status_fifo_almost_full_i  in  1  status FIFO almost full

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset clears all outputs and state:
  - all strobes and read go to 0; addr, bcount, data and status outputs go to 0.
  - command queue is flushed; sequence counter goes to 0; state goes to IDLE.
- Reset mid-burst abandons the burst. Beats still in flight after reset release are ignored because the FSM is in IDLE.
- Command queue is a register FIFO holding {bytes[15:0], addr[31:0]}.
  - dma_rd_fifo_full_o = (count == CMD_FIFO_DEPTH), driven from registers.
  - A push while full is dropped, even if a pop occurs in the same cycle.
  - A push and pop in the same non-full cycle leaves the count unchanged.
- Beats per command = ceil(bytes/32) = bytes[15:5] + |bytes[4:0], held in a 12-bit remaining-beat counter.
- FSM states:
  - IDLE: queue non-empty -> LD_CMD.
  - LD_CMD: pop the queue; latch addr, bytes and remaining beats. Remaining == 0 -> STATUS, else -> CHECK.
  - CHECK: wait until dma_data_fifo_almost_full_i == 0. Then burst = min(remaining, MAX_BURST) and load addr/bcount -> RD_REQ.
  - RD_REQ: rd_master_read_o = 1 with addr/bcount held stable. In the cycle wait_req_i == 0, the request is accepted -> WAIT_DATA with beats_left = burst.
  - WAIT_DATA: each data_valid_i decrements beats_left and remaining. On the last beat: remaining after decrement > 0 -> CHECK with addr += burst*32 (32-bit wrap allowed); else -> STATUS.
  - STATUS: wait until dma_status_fifo_almost_full_i == 0. Then pulse dma_status_fifo_wr_req_o for one cycle, increment the sequence counter -> IDLE.
- Only one burst is outstanding at a time.
- Status word:
  - [15:0] bytes requested (ceil to beats is not reflected back).
  - [23:16] 8-bit command sequence number, wraps 255->0.
  - [24] zero-length flag.
- Data path:
  - Each data_valid_i beat in WAIT_DATA is registered to dma_data_o, with dma_data_fifo_wr_req_o asserted exactly one cycle later.
  - Back-to-back beats give back-to-back strobes.
  - data_valid_i outside WAIT_DATA is ignored.
- The block never back-pressures readdata. Integration requires the almost-full threshold to leave >= MAX_BURST+1 free entries.
- Latency: a command pushed into an empty queue while IDLE drives rd_master_read_o high 4 cycles after the push cycle (queue register, IDLE, LD_CMD, CHECK), assuming no almost-full stall.

Test Plan:
1. Push addr 0x1000_0000, bytes 100, wait_req low -> one burst addr 0x1000_0000, bcount 4; 4 data strobes; status 0x0000064 (seq 0, flag 0).
2. Push bytes 1024, MAX_BURST 16 -> bursts at 0x..0000 and 0x..0200, each bcount 16; 32 strobes with data in order; single status with bytes 1024.
3. Hold wait_req high 3 cycles in RD_REQ -> read stays high with addr/bcount stable for 4 cycles; exactly one burst accepted.
4. Assert data almost_full before the second burst -> FSM stays in CHECK, read low; releases the cycle after almost_full drops. Assert status almost_full -> wr_req deferred until deassert.
5. Push bytes 0 -> no AVMM read; status {1, seq, 16'h0}. 257 commands -> seq wraps to 0.
6. Push 33 commands with no pops -> full after 32, 33rd dropped. Then assert reset mid-WAIT_DATA -> outputs go to 0 immediately, queue empty, late beats produce no strobes.
